// File: rtl/cmp_pkg.sv
// Shared definitions for the bitwise magnitude comparators: the result codes
// used by the parallel and serial blocks, and the serial block's FSM states.
package cmp_pkg;

    localparam logic [1:0] CMP_INV = 2'b00;
    localparam logic [1:0] CMP_GT  = 2'b01;
    localparam logic [1:0] CMP_LT  = 2'b10;
    localparam logic [1:0] CMP_EQ  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } cmp_state_t;

endpackage

// File: rtl/serial_bitwise_comparator.sv
// Bit-serial magnitude comparator: takes a/b one bit pair per accepted beat,
// MSB first, and reports the parallel comparator's result code after WIDTH beats.
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready;
// in_ready is high only in SHIFT, and a beat presented together with start is dropped.
module serial_bitwise_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    input  logic       a_bit,
    input  logic       b_bit,
    output logic       in_ready,
    output logic       busy,
    output logic       done,
    output logic [1:0] o
);

    localparam int CW = $clog2(WIDTH + 1);

    cmp_state_t    state;
    cmp_state_t    state_nx;
    logic [CW-1:0] cnt;
    logic          decided;
    logic [1:0]    code;
    logic          accept;
    logic          last;
    logic [1:0]    beat_code;

    assign accept = (state == SHIFT) && in_valid && !start;
    assign last   = accept && (cnt == CW'(1));

    // The first differing bit (MSB first) settles the order for good.
    always_comb begin
        beat_code = CMP_EQ;
        if (decided) begin
            beat_code = code;
        end else if (a_bit != b_bit) begin
            beat_code = a_bit ? CMP_GT : CMP_LT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = SHIFT;
            end
            SHIFT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (start) begin
                    state_nx = SHIFT;
                end else if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = start ? SHIFT : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            decided <= 1'b0;
            code    <= CMP_INV;
            o       <= CMP_INV;
        end else if (start) begin
            cnt     <= CW'(WIDTH);
            decided <= 1'b0;
            code    <= CMP_INV;
            o       <= CMP_INV;
        end else if (accept) begin
            cnt <= cnt - CW'(1);
            if (!decided && (a_bit != b_bit)) begin
                decided <= 1'b1;
                code    <= beat_code;
            end
            // o stays 00 through the frame and only takes the final code here.
            if (last) o <= beat_code;
        end
    end

endmodule

// File: tb/tb_serial_bitwise_comparator.sv
// Bench for serial_bitwise_comparator at WIDTH 1, 4 and 8 on a shared input bus,
// checked every cycle against an integer-accumulating reference model.
module tb_serial_bitwise_comparator;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic       a_bit;
    logic       b_bit;
    logic [2:0] rdy;
    logic [2:0] bsy;
    logic [2:0] dn;
    logic [1:0] oo [3];

    int n_vec = 0;
    int n_err = 0;

    serial_bitwise_comparator #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .a_bit(a_bit), .b_bit(b_bit), .in_ready(rdy[0]), .busy(bsy[0]),
        .done(dn[0]), .o(oo[0])
    );
    serial_bitwise_comparator #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .a_bit(a_bit), .b_bit(b_bit), .in_ready(rdy[1]), .busy(bsy[1]),
        .done(dn[1]), .o(oo[1])
    );
    serial_bitwise_comparator #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .a_bit(a_bit), .b_bit(b_bit), .in_ready(rdy[2]), .busy(bsy[2]),
        .done(dn[2]), .o(oo[2])
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int wof(input int k);
        return (k == 0) ? 1 : (k == 1) ? 4 : 8;
    endfunction

    // Reference: gather the accepted bits of a frame into integers and compare them.
    bit          m_act  [3];
    int          m_n    [3];
    logic [31:0] m_a    [3];
    logic [31:0] m_b    [3];
    logic        m_done [3];
    logic [1:0]  m_o    [3];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_act[k] = 1'b0; m_n[k] = 0; m_a[k] = '0; m_b[k] = '0;
                m_done[k] = 1'b0; m_o[k] = 2'b00;
            end else begin
                m_done[k] = 1'b0;
                if (start) begin
                    m_act[k] = 1'b1; m_n[k] = 0; m_a[k] = '0; m_b[k] = '0;
                    m_o[k] = 2'b00;
                end else if (m_act[k] && in_valid) begin
                    m_a[k] = {m_a[k][30:0], a_bit};
                    m_b[k] = {m_b[k][30:0], b_bit};
                    m_n[k] = m_n[k] + 1;
                    if (m_n[k] == wof(k)) begin
                        m_act[k]  = 1'b0;
                        m_done[k] = 1'b1;
                        m_o[k] = (m_a[k] > m_b[k]) ? 2'b01 :
                                 (m_a[k] < m_b[k]) ? 2'b10 : 2'b11;
                    end
                end
            end
        end
    end

    // scoreboard compare helpers
    task automatic chk(input string name, input int k, input logic [1:0] got,
                       input logic [1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s w%0d @%0t: got %0h expected %0h", name, wof(k), $time, got, exp);
        end
    endtask

    task automatic pin(input string name, input logic [1:0] got, input logic [1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk("in_ready", k, {1'b0, rdy[k]}, {1'b0, m_act[k]});
            chk("busy", k, {1'b0, bsy[k]}, {1'b0, m_act[k]});
            chk("done", k, {1'b0, dn[k]}, {1'b0, m_done[k]});
            chk("o", k, oo[k], m_o[k]);
        end
    end

    // driver tasks
    task automatic drive(input logic s, input logic v, input logic a, input logic b);
        @(negedge clk);
        start = s; in_valid = v; a_bit = a; b_bit = b;
    endtask

    task automatic noise();
        drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic frame(input int w, input logic [31:0] a, input logic [31:0] b,
                         input int maxgap);
        drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
        for (int i = w - 1; i >= 0; i--) begin
            repeat ($urandom_range(0, maxgap)) noise();
            drive(1'b0, 1'b1, a[i], b[i]);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
        repeat (2) @(negedge clk);
        pin("rst_o", oo[1], 2'b00);
        pin("rst_busy", {1'b0, bsy[1]}, 2'b00);
        pin("rst_ready", {1'b0, rdy[1]}, 2'b00);
        pin("rst_done", {1'b0, dn[1]}, 2'b00);
        #2 rst_n = 1'b1;
        noise();
        noise();

        // a=1010 > b=0111
        frame(4, 32'b1010, 32'b0111, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        pin("t1_done", {1'b0, dn[1]}, 2'b01);
        pin("t1_o", oo[1], 2'b01);

        // a=0011 < b=0100, result held until the next start
        frame(4, 32'b0011, 32'b0100, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        pin("t2_done", {1'b0, dn[1]}, 2'b01);
        pin("t2_o", oo[1], 2'b10);
        repeat (3) begin
            noise();
            pin("t2_hold_o", oo[1], 2'b10);
            pin("t2_hold_done", {1'b0, dn[1]}, 2'b00);
        end

        // equal operands 1001 with valid on cycles 0,2,3,6
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        noise();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        noise();
        noise();
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        pin("t3_no_early_done", {1'b0, dn[1]}, 2'b00);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        pin("t3_done", {1'b0, dn[1]}, 2'b01);
        pin("t3_o", oo[1], 2'b11);

        // abort after 2 beats; the beat riding on the restart would flip the result
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (4) drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        pin("t4_done", {1'b0, dn[1]}, 2'b01);
        pin("t4_o", oo[1], 2'b01);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        pin("t4_single_done", {1'b0, dn[1]}, 2'b00);

        // asynchronous reset mid-frame
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        #1;
        pin("t5_busy", {1'b0, bsy[1]}, 2'b00);
        pin("t5_ready", {1'b0, rdy[1]}, 2'b00);
        pin("t5_done", {1'b0, dn[1]}, 2'b00);
        pin("t5_o", oo[1], 2'b00);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        frame(4, 32'b0001, 32'b0000, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        pin("t5_after_done", {1'b0, dn[1]}, 2'b01);
        pin("t5_after_o", oo[1], 2'b01);

        // all 256 pairs at WIDTH 4, random gaps, sometimes restarting on the done cycle
        for (int p = 0; p < 256; p++) begin
            frame(4, 32'(p >> 4), 32'(p & 15), 2);
            if ($urandom_range(0, 3) != 0) repeat ($urandom_range(1, 2)) noise();
        end

        // WIDTH 1: all pairs plus random
        for (int p = 0; p < 16; p++) begin
            frame(1, 32'((p >> 1) & 1), 32'(p & 1), 2);
            if ($urandom_range(0, 1) != 0) noise();
        end

        // WIDTH 8: random pairs, a third of them equal
        for (int p = 0; p < 60; p++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = 32'($urandom_range(0, 255));
            rb = ($urandom_range(0, 2) == 0) ? ra : 32'($urandom_range(0, 255));
            frame(8, ra, rb, 2);
            if ($urandom_range(0, 3) != 0) repeat ($urandom_range(1, 2)) noise();
        end

        repeat (4) noise();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
